noc_output_scheduler: RTL and testbench
=======================================

# noc_output_scheduler

Round-robin wormhole scheduler for one router output port. It shares the output among 6 input ports and locks the winner from head flit to tail flit. It gates every transfer on credits returned by the downstream input buffer. It sits between the input buffers and the crossbar output register, and replaces the fixed-priority grant path with fair arbitration plus credit-based flow control.

## Interface
Parameters:
- NUM_IN, 6, number of competing input ports
- FLIT_W, 67, flit width; bits [2:0] hold the flit type, bits [5:3] hold the destination port
- PORT_ID, 0, 3-bit id of this output port
- CREDITS, 4, depth of the downstream buffer; the credit counter is $clog2(CREDITS+1) bits wide
- WDOG_CYCLES, 64, watchdog limit; used only with SCHED_WATCHDOG_EN

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flit_in  in  NUM_IN*FLIT_W  packed input flits; port i occupies [i*FLIT_W +: FLIT_W]
- valid_in  in  NUM_IN  flit present on port i
- ready_out  out  NUM_IN  combinational; the flit on port i is consumed this cycle
- flit_out  out  FLIT_W  registered forwarded flit
- valid_out  out  1  registered; flit_out is valid
- credit_in  in  1  single-cycle pulse; one downstream slot freed
- grant_out  out  NUM_IN  registered one-hot lock owner; 0 when unlocked
- busy  out  1  registered; lock held
- cred_err  out  1  sticky; credit_in arrived while the counter was already at CREDITS
- timeout  out  1  one-cycle pulse on watchdog release; constant 0 without the macro

## Operation
- Flit types: 3'b011 = head, 3'b010 = body, 3'b000 = tail. Other codes are treated as body.
- Request i: valid_in[i] & type==head & dest==PORT_ID.
- Canfwd: credit count > 0. The registered count is used, so a credit_in this cycle is not visible until the next cycle.
- FSM state IDLE:
  - If any request and canfwd, pick the winner: the first requester scanning upward from ptr, wrapping 5→0.
  - Assert ready_out[winner] and forward the head flit.
  - Go to LOCKED with owner = winner.
  - Tail or body flits from unlocked ports are never consumed.
- FSM state LOCKED:
  - ready_out[owner] = valid_in[owner] & canfwd. All other ready_out bits are 0.
  - Every forwarded flit of any type is passed unchanged.
  - Forwarding a tail → go to IDLE and set ptr = owner+1, wrapping 5→0.
- Forward: flit_out <= selected flit and valid_out <= 1 on the next edge. Otherwise valid_out <= 0 and flit_out holds its value.
- Credit counter:
  - Forward without credit_in: −1.
  - credit_in without forward: +1, saturating at CREDITS. A credit_in at CREDITS sets cred_err.
  - Forward and credit_in together: unchanged.
- Each packet is its own lock. In a single-flit scenario a head flit never releases; a tail is required.

## Timing
- Reset values:
  - flit_out = 0, valid_out = 0, grant_out = 0, busy = 0
  - cred_err = 0, timeout = 0
  - credit count = CREDITS, ptr = 0, state = IDLE
- Latency: input flit to valid_out is 1 cycle. ready_out is asserted in the same cycle as consumption.
- The head flit is granted and consumed in the same cycle. grant_out and busy rise on the following edge.
- The tail is forwarded in cycle T. At T+1 grant_out and busy are 0. A new head can be granted at T+1.
- Maximum throughput is 1 flit/cycle while credits are > 0.
- Reset asserted mid-packet drops the lock and restores credits to CREDITS immediately. The pending flit_out is discarded.

## Configuration
- SCHED_WATCHDOG_EN defined:
  - In LOCKED, a counter increments each cycle valid_in[owner]==0 and clears on any owner flit.
  - On reaching WDOG_CYCLES: release to IDLE, set ptr = owner+1, pulse timeout for 1 cycle. No flit is forwarded that cycle.
- SCHED_WATCHDOG_EN undefined: no counter, timeout tied to 0, and the lock is held indefinitely.

## Test plan
- Reset: after deassert, credits=4, valid_out=0, grant_out=0. Apply credit_in → cred_err=1.
- Single packet on port 2 (head dest=PORT_ID, body, tail, back to back) → valid_out on cycles 1–3 with identical flits, grant_out=6'b000100 for 3 cycles, then 0; credits end at 1.
- Heads on ports 0, 3, 5 simultaneously, 1-flit body + tail each, credit_in every cycle → service order 0, 3, 5; repeat → order 0, 3, 5 again with no port starved.
- Credit stall: CREDITS=4, 6-flit packet, no credit_in → 4 flits forwarded and ready_out[owner]=0. Pulse credit_in twice → 2 more flits.
- Non-owner head arriving mid-packet is not consumed until the cycle after the owner's tail. A head with dest≠PORT_ID is never granted.
- With SCHED_WATCHDOG_EN and WDOG_CYCLES=8: owner sends head then idles → timeout pulses 8 cycles later, busy=0, the next requester is granted. Without the macro busy stays 1.

Source files
------------

// File: rtl/noc_output_scheduler.sv
`default_nettype none
// ============================================================================
// noc_output_scheduler : round-robin wormhole scheduler with credit flow
// control for one router output port. Optional watchdog: SCHED_WATCHDOG_EN.
// Revision : 1.0
// ============================================================================
module noc_output_scheduler #(
  parameter int NUM_IN      = 6,
  parameter int FLIT_W      = 67,
  parameter int PORT_ID     = 0,
  parameter int CREDITS     = 4,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*FLIT_W-1:0] flit_in,
  input  logic [NUM_IN-1:0]        valid_in,
  output logic [NUM_IN-1:0]        ready_out,
  output logic [FLIT_W-1:0]        flit_out,
  output logic                     valid_out,
  input  logic                     credit_in,
  output logic [NUM_IN-1:0]        grant_out,
  output logic                     busy,
  output logic                     cred_err,
  output logic                     timeout
);

  localparam int OW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [2:0]    C_HEAD     = 3'b011;
  localparam logic [2:0]    C_TAIL     = 3'b000;
  localparam logic [2:0]    C_PORT     = 3'(PORT_ID);
  localparam logic [CW-1:0] C_CRED_MAX = CW'(CREDITS);
  localparam logic [OW-1:0] C_LAST     = OW'(NUM_IN - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [OW-1:0]       r_owner, r_ptr, w_owner_nxt, w_ptr_nxt, w_sel, w_owner_inc;
  logic [CW-1:0]       r_cred;
  logic [FLIT_W-1:0]   r_flit, w_sel_flit;
  logic                r_valid, r_cred_err;
  logic                w_fwd, w_canfwd, w_any;
  logic [NUM_IN-1:0]   r_grant, w_req, w_ready;
  logic [FLIT_W-1:0]   w_flits [NUM_IN];

  for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
    assign w_flits[i] = flit_in[i*FLIT_W +: FLIT_W];
    assign w_req[i]   = valid_in[i] && (w_flits[i][2:0] == C_HEAD) && (w_flits[i][5:3] == C_PORT);
  end

  // Registered count only: a credit returned this cycle is usable next cycle.
  assign w_canfwd    = (r_cred != '0);
  assign w_owner_inc = (r_owner == C_LAST) ? '0 : r_owner + 1'b1;

  always_comb begin : rr_pick
    logic [OW:0] idx;
    w_sel = r_ptr;
    w_any = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = {1'b0, r_ptr} + (OW+1)'(k);
      if (idx >= (OW+1)'(NUM_IN)) idx = idx - (OW+1)'(NUM_IN);
      if (!w_any && w_req[idx[OW-1:0]]) begin
        w_any = 1'b1;
        w_sel = idx[OW-1:0];
      end
    end
  end

`ifdef SCHED_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] C_WD_LAST = WW'(WDOG_CYCLES - 1);
  logic [WW-1:0] r_wdog;
  logic          r_timeout, w_timeout_nxt;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_ready     = '0;
    w_fwd       = 1'b0;
    w_sel_flit  = w_flits[r_owner];
`ifdef SCHED_WATCHDOG_EN
    w_timeout_nxt = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_any && w_canfwd) begin
          w_ready[w_sel] = 1'b1;
          w_fwd          = 1'b1;
          w_sel_flit     = w_flits[w_sel];
          w_state_nxt    = S_LOCKED;
          w_owner_nxt    = w_sel;
        end
      end
      S_LOCKED: begin
        if (valid_in[r_owner] && w_canfwd) begin
          w_ready[r_owner] = 1'b1;
          w_fwd            = 1'b1;
          if (w_sel_flit[2:0] == C_TAIL) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = w_owner_inc;
          end
        end
`ifdef SCHED_WATCHDOG_EN
        else if (!valid_in[r_owner] && (r_wdog == C_WD_LAST)) begin
          w_state_nxt   = S_IDLE;
          w_ptr_nxt     = w_owner_inc;
          w_timeout_nxt = 1'b1;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_flit     <= '0;
      r_valid    <= 1'b0;
      r_cred     <= C_CRED_MAX;
      r_cred_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= (w_state_nxt == S_LOCKED) ? (NUM_IN'(1) << w_owner_nxt) : '0;
      r_valid <= w_fwd;
      if (w_fwd) r_flit <= w_sel_flit;
      // Simultaneous forward and credit return cancel out.
      if (w_fwd && !credit_in) begin
        r_cred <= r_cred - CW'(1);
      end else if (!w_fwd && credit_in) begin
        if (r_cred == C_CRED_MAX) r_cred_err <= 1'b1;
        else                      r_cred     <= r_cred + CW'(1);
      end
    end
  end

`ifdef SCHED_WATCHDOG_EN
  // Counts owner-silent cycles; any owner flit or release clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout_nxt;
      if (r_state != S_LOCKED || valid_in[r_owner] || w_state_nxt == S_IDLE) r_wdog <= '0;
      else                                                                   r_wdog <= r_wdog + 1'b1;
    end
  end
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  assign ready_out = w_ready;
  assign flit_out  = r_flit;
  assign valid_out = r_valid;
  assign grant_out = r_grant;
  assign busy      = (r_state == S_LOCKED);
  assign cred_err  = r_cred_err;

endmodule
`default_nettype wire

// File: tb/tb_noc_output_scheduler.sv
`default_nettype none
// tb_noc_output_scheduler : directed and randomized checks of the output
// scheduler against a transaction-level reference model.
module tb_noc_output_scheduler;

  localparam int NUM_IN  = 6;
  localparam int FW      = 67;
  localparam int PORT_ID = 3;
  localparam int CREDITS = 4;
  localparam int WDOG    = 8;
  typedef logic [FW-1:0] flit_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NUM_IN*FW-1:0] flit_in = '0;
  logic [NUM_IN-1:0]    valid_in = '0;
  logic [NUM_IN-1:0]    ready_out;
  logic [FW-1:0]        flit_out;
  logic                 valid_out;
  logic                 credit_in = 1'b0;
  logic [NUM_IN-1:0]    grant_out;
  logic                 busy, cred_err, timeout;

  always #5 clk = ~clk;

  noc_output_scheduler #(
    .NUM_IN(NUM_IN), .FLIT_W(FW), .PORT_ID(PORT_ID), .CREDITS(CREDITS), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk), .rst(rst), .flit_in(flit_in), .valid_in(valid_in), .ready_out(ready_out),
    .flit_out(flit_out), .valid_out(valid_out), .credit_in(credit_in), .grant_out(grant_out),
    .busy(busy), .cred_err(cred_err), .timeout(timeout)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state (packet-level rules expressed with integers)
  bit    m_locked, m_valid, m_err, m_tmo;
  int    m_owner, m_ptr, m_cred, m_wd;
  flit_t m_flit;

  // Source queues per input port
  flit_t             q [NUM_IN][$];
  int                age [NUM_IN];
  bit                bubbles;
  int                order[$];
  logic [NUM_IN-1:0] prev_grant;
  int                nvalid;
  bit                saw_tmo;

  function automatic void model_reset();
    m_locked = 0; m_valid = 0; m_err = 0; m_tmo = 0;
    m_owner = 0; m_ptr = 0; m_cred = CREDITS; m_wd = 0; m_flit = '0;
    for (int p = 0; p < NUM_IN; p++) begin q[p].delete(); age[p] = 0; end
    prev_grant = '0;
  endfunction

  function automatic flit_t make_flit(input logic [2:0] typ, input int dest);
    flit_t f;
    f = flit_t'({$urandom(), $urandom(), $urandom()});
    f[2:0] = typ;
    f[5:3] = 3'(dest);
    return f;
  endfunction

  function automatic void push_pkt(input int p, input int nbody);
    logic [2:0] bt;
    q[p].push_back(make_flit(3'b011, PORT_ID));
    for (int b = 0; b < nbody; b++) begin
      case ($urandom_range(0, 5))
        0: bt = 3'b010; 1: bt = 3'b001; 2: bt = 3'b100;
        3: bt = 3'b101; 4: bt = 3'b110; default: bt = 3'b111;
      endcase
      q[p].push_back(make_flit(bt, $urandom_range(0, 7)));
    end
    q[p].push_back(make_flit(3'b000, $urandom_range(0, 7)));
  endfunction

  function automatic void push_stray(input int p);
    q[p].push_back(make_flit(3'b011, (PORT_ID + 1 + $urandom_range(0, 6)) % 8));
  endfunction

  task automatic step(input bit cin);
    logic [NUM_IN-1:0] vin, er, eg;
    flit_t             cur [NUM_IN];
    int                fwd;
    @(negedge clk);
    eg = m_locked ? NUM_IN'(1 << m_owner) : '0;
    chk("flit_out", flit_out, m_flit);
    chk("valid_out", valid_out, m_valid);
    chk("grant_out", grant_out, eg);
    chk("busy", busy, m_locked);
    chk("cred_err", cred_err, m_err);
    chk("timeout", timeout, m_tmo);
    if (timeout) saw_tmo = 1;
    if (valid_out) nvalid++;
    if (grant_out != prev_grant && grant_out != '0)
      for (int p = 0; p < NUM_IN; p++) if (grant_out[p]) order.push_back(p);
    prev_grant = grant_out;

    for (int p = 0; p < NUM_IN; p++) begin
      cur[p] = (q[p].size() > 0) ? q[p][0] : '0;
      vin[p] = (q[p].size() > 0) && !(bubbles && $urandom_range(0, 3) == 0);
      flit_in[p*FW +: FW] = cur[p];
    end
    valid_in  = vin;
    credit_in = cin;
    #1;

    fwd = -1;
    if (!m_locked) begin
      if (m_cred > 0)
        for (int k = 0; k < NUM_IN; k++) begin
          int p;
          p = (m_ptr + k) % NUM_IN;
          if (fwd < 0 && vin[p] && cur[p][2:0] == 3'b011 && cur[p][5:3] == PORT_ID) fwd = p;
        end
    end else if (vin[m_owner] && m_cred > 0) begin
      fwd = m_owner;
    end
    er = '0;
    if (fwd >= 0) er[fwd] = 1'b1;
    chk("ready_out", ready_out, er);

    for (int p = 0; p < NUM_IN; p++) begin
      if (p == fwd) begin
        void'(q[p].pop_front());
        age[p] = 0;
      end else if (vin[p] && cur[p][2:0] == 3'b011 && cur[p][5:3] != PORT_ID) begin
        age[p]++;
        if (age[p] > 3) begin void'(q[p].pop_front()); age[p] = 0; end
      end
    end

    m_tmo = 0;
`ifdef SCHED_WATCHDOG_EN
    if (m_locked && fwd < 0 && !vin[m_owner]) begin
      if (m_wd == WDOG - 1) begin
        logic [2:0] t;
        m_locked = 0; m_tmo = 1; m_wd = 0;
        m_ptr = (m_owner + 1) % NUM_IN;
        while (q[m_owner].size() > 0) begin
          t = q[m_owner][0][2:0];
          void'(q[m_owner].pop_front());
          if (t == 3'b000) break;
        end
      end else m_wd++;
    end else m_wd = 0;
`endif
    if (fwd >= 0) begin
      m_flit  = cur[fwd];
      m_valid = 1;
      if (!m_locked) begin
        m_locked = 1; m_owner = fwd;
      end else if (cur[fwd][2:0] == 3'b000) begin
        m_locked = 0; m_ptr = (m_owner + 1) % NUM_IN;
      end
    end else m_valid = 0;

    if (fwd >= 0 && !cin) m_cred--;
    else if (fwd < 0 && cin) begin
      if (m_cred == CREDITS) m_err = 1;
      else                   m_cred++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; valid_in = '0; credit_in = 1'b0; flit_in = '0;
    #1;
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_grant_out", grant_out, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_flit_out", flit_out, '0);
    chk("rst_cred_err", cred_err, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_drain(input int limit, input int cmode);
    bit drained;
    drained = 0;
    for (int c = 0; c < limit && !drained; c++) begin
      drained = !m_locked && !m_valid;
      for (int p = 0; p < NUM_IN; p++) if (q[p].size() > 0) drained = 0;
      if (!drained) step(cmode == 1 ? 1'b1 : (cmode == 2 ? ($urandom_range(0, 9) < 6) : 1'b0));
    end
    chk("drain_in_time", drained, 1'b1);
  endtask

  int rr_exp[6] = '{0, 3, 5, 0, 3, 5};

  initial begin
    bubbles = 0; saw_tmo = 0;
    do_reset();
    step(0); step(1); step(0);
    chk("cred_err_sticky", cred_err, 1'b1);

    // Single packet on port 2, no credit returns
    do_reset();
    nvalid = 0;
    push_pkt(2, 1);
    repeat (6) step(0);
    chk("single_nvalid", nvalid, 3);
    push_pkt(2, 0);
    repeat (5) step(0);
    chk("single_one_credit_left", nvalid, 4);
    chk("pre_reset_busy", busy, 1'b1);
    do_reset();

    // Round robin over ports 0, 3, 5 twice
    order.delete();
    push_pkt(0, 1); push_pkt(3, 1); push_pkt(5, 1);
    wait_drain(60, 1);
    push_pkt(0, 1); push_pkt(3, 1); push_pkt(5, 1);
    wait_drain(60, 1);
    chk("rr_count", order.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("rr_order%0d", i), (i < order.size()) ? order[i] : -1, rr_exp[i]);

    // Credit stall on a 6-flit packet
    do_reset();
    nvalid = 0;
    push_pkt(1, 4);
    repeat (10) step(0);
    chk("stall_nvalid", nvalid, 4);
    step(1); step(0); step(1);
    repeat (6) step(0);
    chk("stall_resume_nvalid", nvalid, 6);

    // Non-owner head mid-packet and a wrong-destination head
    order.delete();
    push_pkt(0, 3); push_stray(1);
    step(1); step(1);
    push_pkt(4, 1);
    wait_drain(60, 1);
    chk("mid_count", order.size(), 2);
    chk("mid_first", (order.size() > 0) ? order[0] : -1, 0);
    chk("mid_second", (order.size() > 1) ? order[1] : -1, 4);

    // Owner sends head then goes silent
    do_reset();
    saw_tmo = 0;
    q[3].push_back(make_flit(3'b011, PORT_ID));
    repeat (WDOG + 4) step(0);
`ifdef SCHED_WATCHDOG_EN
    chk("wdog_released", busy, 1'b0);
    chk("wdog_pulsed", saw_tmo, 1'b1);
`else
    chk("hold_busy", busy, 1'b1);
    chk("hold_no_timeout", saw_tmo, 1'b0);
`endif
    do_reset();

    // Randomized traffic
    bubbles = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NUM_IN; p++)
        if (q[p].size() == 0 && $urandom_range(0, 9) == 0) begin
          if ($urandom_range(0, 4) == 0) push_stray(p);
          else                           push_pkt(p, $urandom_range(0, 4));
        end
      step($urandom_range(0, 9) < 6);
    end
    bubbles = 0;
    wait_drain(500, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
